// File: rtl/vec5_pair_packer_if.sv
// vec5_pair_packer_if: word-in / pair-out handshake bundle; master drives words and accepts pairs, slave is the packer
interface vec5_pair_packer_if #(parameter int DEPTH = 4, parameter int W = 5);
  logic                           in_valid;
  logic                           in_ready;
  logic [1:W]                     in_data;
  logic                           flush;
  logic                           out_valid;
  logic                           out_ready;
  logic [1:W]                     out_a;
  logic [1:W]                     out_aa;
  logic                           out_odd;
  logic [$clog2(DEPTH+1)-1:0]     count;
  modport master (output in_valid, in_data, flush, out_ready,
                  input  in_ready, out_valid, out_a, out_aa, out_odd, count);
  modport slave  (input  in_valid, in_data, flush, out_ready,
                  output in_ready, out_valid, out_a, out_aa, out_odd, count);
endinterface

// File: rtl/vec5_pair_packer.sv
// vec5_pair_packer: buffers W-bit words in a DEPTH-entry FIFO and emits them as ordered pairs (a older, aa younger); flush drains an odd remnant; ports clk, rst (async high), bus (slave modport)
module vec5_pair_packer #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input logic               clk,
  input logic               rst,
  vec5_pair_packer_if.slave bus
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, rd1;
  logic [CW-1:0] count_q, count_d;
  logic [1:W]    mem_q [DEPTH];
  logic          push, pop, odd, vld;
  // a lone word can only leave while draining; in RUN it waits for its partner
  always_comb begin
    odd     = (state_q == FLUSH) && (count_q == CW'(1));
    vld     = (state_q == FLUSH) ? (count_q != '0) : (count_q >= CW'(2));
    push    = bus.in_valid && bus.in_ready;
    pop     = vld && bus.out_ready;
    rd1     = rd_q + PW'(1);
    rd_d    = rd_q + (pop ? (odd ? PW'(1) : PW'(2)) : '0);
    wr_d    = wr_q + PW'(push);
    count_d = count_q + CW'(push) - (pop ? (odd ? CW'(1) : CW'(2)) : '0);
    state_d = (state_q == RUN) ? (bus.flush ? FLUSH : RUN) : ((count_q == '0) ? RUN : FLUSH);
  end
  assign bus.in_ready  = (state_q == RUN) && (count_q < CW'(DEPTH));
  assign bus.out_valid = vld;
  assign bus.out_a     = vld ? mem_q[rd_q] : '0;
  assign bus.out_aa    = (vld && !odd) ? mem_q[rd1] : '0;
  assign bus.out_odd   = odd;
  assign bus.count     = count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.in_data;
  end
endmodule

// File: tb/tb_vec5_pair_packer.sv
// tb_vec5_pair_packer: scoreboard bench for vec5_pair_packer
module tb_vec5_pair_packer;
  localparam int DEPTH = 4;
  localparam int W     = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [1:W] q[$];
  bit fl = 1'b0;
  always #5 clk = ~clk;
  vec5_pair_packer_if #(.DEPTH(DEPTH), .W(W)) bus();
  vec5_pair_packer #(.DEPTH(DEPTH), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_word(input logic [1:W] w);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
    end
    check("push_accepted", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    int n;
    int npop;
    n = q.size();
    if (rst) begin
      q.delete();
      fl = 1'b0;
    end else begin
      check("in_ready", 32'(bus.in_ready), 32'(!fl && n < DEPTH));
      check("out_valid", 32'(bus.out_valid), 32'(fl ? n >= 1 : n >= 2));
      check("count", 32'(bus.count), 32'(n));
      if (bus.out_valid) begin
        check("out_odd", 32'(bus.out_odd), 32'(fl && n == 1));
        if (n >= 1) check("out_a", 32'(bus.out_a), 32'(q[0]));
        check("out_aa", 32'(bus.out_aa), (n >= 2 && !(fl && n == 1)) ? 32'(q[1]) : 32'd0);
      end else begin
        check("idle_zero", 32'({bus.out_a, bus.out_aa, bus.out_odd}), 32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        npop = (fl && n == 1) ? 1 : 2;
        for (int i = 0; i < npop && q.size() > 0; i++) void'(q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
      fl = fl ? (n != 0) : bus.flush;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int z;
    int v;
    time t0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_out_odd", 32'(bus.out_odd), 32'd0);
    tick();
    bus.out_ready = 1'b1;
    push_word(5'b10110);
    push_word(5'b00011);
    @(negedge clk);
    check("pair_valid", 32'(bus.out_valid), 32'd1);
    check("pair_a", 32'(bus.out_a), 32'b10110);
    check("pair_aa", 32'(bus.out_aa), 32'b00011);
    check("pair_odd", 32'(bus.out_odd), 32'd0);
    tick();
    @(negedge clk);
    check("pair_count_after", 32'(bus.count), 32'd0);
    tick();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_word(5'(16 + i));
    @(negedge clk);
    check("full_count", 32'(bus.count), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    fork
      begin
        repeat (3) tick();
        bus.out_ready = 1'b1;
      end
    join_none
    push_word(5'd21);
    push_word(5'd22);
    repeat (3) tick();
    @(negedge clk);
    check("full_drained", 32'(bus.count), 32'd0);
    tick();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) push_word(5'(i));
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_odd", 32'(bus.out_odd), 32'd1);
    check("flush_a", 32'(bus.out_a), 32'd3);
    check("flush_aa", 32'(bus.out_aa), 32'd0);
    repeat (3) tick();
    @(negedge clk);
    check("flush_done_ready", 32'(bus.in_ready), 32'd1);
    check("flush_done_count", 32'(bus.count), 32'd0);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    z = 0;
    v = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      z += int'(!bus.in_ready);
      v += int'(bus.out_valid);
      tick();
    end
    check("empty_flush_cycles", 32'(z), 32'd1);
    check("empty_flush_valid", 32'(v), 32'd0);
    t0 = $time;
    for (int i = 0; i < 40; i++) push_word(5'($urandom_range(0, 31)));
    check("stream_cycles", 32'(($time - t0) / 10), 32'd40);
    repeat (3) tick();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) push_word(5'(8 + i));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (2) tick();
    check("preflush_count", 32'(bus.count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_count_after", 32'(bus.count), 32'd0);
    tick();
    bus.out_ready = 1'b1;
    push_word(5'd30);
    push_word(5'd31);
    repeat (3) tick();
    check("sb_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
